// File: rtl/gift_pkg.sv
// Shared types and constants for the GIFT multi-slot state bank.
package gift_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    ACTIVE = 2'b01,
    DONE   = 2'b10
  } slot_state_t;

  localparam int unsigned GIFT64_ROUNDS  = 28;
  localparam int unsigned GIFT128_ROUNDS = 40;
  localparam int unsigned GIFT64_W       = 64;
  localparam int unsigned GIFT128_W      = 128;

  // Stall cycles tolerated before the watchdog flags an error.
  localparam int unsigned WDOG_LIMIT     = 64;

endpackage

// File: rtl/gift_slot_prio_enc.sv
// Lowest-index priority encoder over a slot request vector.
module gift_slot_prio_enc #(
  parameter  int unsigned NUM_SLOTS = 4,
  localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic [NUM_SLOTS-1:0] req,
  output logic                 found,
  output logic [SLOT_W-1:0]    idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (req[i] && !found) begin
        found = 1'b1;
        idx   = SLOT_W'(i);
      end
    end
  end

endmodule

// File: rtl/gift_state_bank.sv
// Multi-slot GIFT cipher-state bank with per-slot FREE/ACTIVE/DONE lifecycle.
// Optional sticky error output enabled by defining GIFT_STATE_BANK_ERR_EN.
module gift_state_bank
  import gift_pkg::*;
#(
  parameter  int unsigned STATE_W   = GIFT128_W,
  parameter  int unsigned NUM_SLOTS = 4,
  parameter  int unsigned ROUNDS    = GIFT128_ROUNDS,
  localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS),
  localparam int unsigned RND_W     = $clog2(ROUNDS + 1)
) (
  input  logic               inClk,
  input  logic               inRstN,
  input  logic               inExtValid,
  output logic               outExtReady,
  input  logic [STATE_W-1:0] inExtData,
  output logic [SLOT_W-1:0]  outExtSlot,
  input  logic               inIntWr,
  input  logic [SLOT_W-1:0]  inIntSlot,
  input  logic [STATE_W-1:0] inIntData,
  input  logic [SLOT_W-1:0]  inRdSlot,
  output logic [STATE_W-1:0] outRdData,
  output logic [RND_W-1:0]   outRdRound,
  output logic               outDoneValid,
  input  logic               inDoneReady,
  output logic [STATE_W-1:0] outDoneData,
  output logic [SLOT_W-1:0]  outDoneSlot
`ifdef GIFT_STATE_BANK_ERR_EN
  ,
  output logic               outErr
`endif
);

  slot_state_t        state_q [NUM_SLOTS];
  slot_state_t        state_d [NUM_SLOTS];
  logic [STATE_W-1:0] data_q  [NUM_SLOTS];
  logic [STATE_W-1:0] data_d  [NUM_SLOTS];
  logic [RND_W-1:0]   rnd_q   [NUM_SLOTS];
  logic [RND_W-1:0]   rnd_d   [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] free_vec;
  logic [NUM_SLOTS-1:0] done_vec;
  logic [NUM_SLOTS-1:0] wr_hit;
  logic                 free_found;
  logic [SLOT_W-1:0]    free_idx;
  logic                 done_found;
  logic [SLOT_W-1:0]    done_idx;
  logic                 load_fire;
  logic                 drain_fire;

  // Comparing against every slot index filters out-of-range targets for free.
  always_comb begin
    free_vec = '0;
    done_vec = '0;
    wr_hit   = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      free_vec[i] = (state_q[i] == FREE);
      done_vec[i] = (state_q[i] == DONE);
      wr_hit[i]   = inIntWr && (inIntSlot == SLOT_W'(i)) && (state_q[i] == ACTIVE);
    end
  end

  gift_slot_prio_enc #(.NUM_SLOTS(NUM_SLOTS)) u_free_enc (
    .req   (free_vec),
    .found (free_found),
    .idx   (free_idx)
  );

  gift_slot_prio_enc #(.NUM_SLOTS(NUM_SLOTS)) u_done_enc (
    .req   (done_vec),
    .found (done_found),
    .idx   (done_idx)
  );

  assign load_fire  = inExtValid && free_found;
  assign drain_fire = done_found && inDoneReady;

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) state_q[i] <= FREE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        FREE: begin
          if (load_fire && (free_idx == SLOT_W'(i))) state_d[i] = ACTIVE;
        end
        ACTIVE: begin
          if (wr_hit[i] && (rnd_q[i] == RND_W'(ROUNDS - 1))) state_d[i] = DONE;
        end
        DONE: begin
          if (drain_fire && (done_idx == SLOT_W'(i))) state_d[i] = FREE;
        end
        default: state_d[i] = FREE;
      endcase
    end
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
        data_q[i] <= '0;
        rnd_q[i]  <= '0;
      end
    end else begin
      data_q <= data_d;
      rnd_q  <= rnd_d;
    end
  end

  // Load and round write can never hit the same slot: one needs FREE, the other ACTIVE.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      data_d[i] = data_q[i];
      rnd_d[i]  = rnd_q[i];
      if (load_fire && (free_idx == SLOT_W'(i))) begin
        data_d[i] = inExtData;
        rnd_d[i]  = '0;
      end else if (wr_hit[i]) begin
        data_d[i] = inIntData;
        rnd_d[i]  = rnd_q[i] + RND_W'(1);
      end
    end
  end

  always_comb begin
    outExtReady  = free_found;
    outExtSlot   = free_idx;
    outDoneValid = done_found;
    outDoneSlot  = done_idx;
    outDoneData  = '0;
    outRdData    = '0;
    outRdRound   = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (done_found && (done_idx == SLOT_W'(i))) outDoneData = data_q[i];
      if (inRdSlot == SLOT_W'(i)) begin
        outRdData  = data_q[i];
        outRdRound = rnd_q[i];
      end
    end
  end

`ifdef GIFT_STATE_BANK_ERR_EN
  logic       err_q;
  logic       err_d;
  logic [6:0] wdog_q;
  logic [6:0] wdog_d;
  logic       stall;
  logic       bad_wr;

  assign stall  = inExtValid && !free_found;
  assign bad_wr = inIntWr && !(|wr_hit);

  // Watchdog saturates at the limit; the next stalled cycle beyond it trips the error.
  always_comb begin
    wdog_d = '0;
    if (stall) wdog_d = (wdog_q == 7'(WDOG_LIMIT)) ? wdog_q : wdog_q + 7'd1;
    err_d = err_q || bad_wr || (stall && (wdog_q == 7'(WDOG_LIMIT)));
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      err_q  <= 1'b0;
      wdog_q <= '0;
    end else begin
      err_q  <= err_d;
      wdog_q <= wdog_d;
    end
  end

  assign outErr = err_q;
`endif

endmodule
